hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline stall/flush controller for the 16-register, 5-stage CPU; works alongside the forwarding logic.
- Detects load-use hazards that forwarding cannot resolve.
- Freezes the pipeline while the data-memory handshake is outstanding, with timeout.
- Squashes wrong-path instructions on taken branches.
- Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes.

Parameters:
REG_W, 4, register address width
MEM_WAIT_MAX, 15, cycles of MEM_WAIT before timeout
PERF_W, 16, performance counter width (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset
id_rs  in  REG_W  source register A of instruction in ID
id_rt  in  REG_W  source register B of instruction in ID
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
idex_memread  in  1  instruction in EX is a load
idex_regrd  in  REG_W  destination of instruction in EX
br_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage has an active memory access
mem_ready  in  1  memory completes access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
idex_stall  out  1  hold ID/EX
exmem_stall  out  1  hold EX/MEM
memwb_bubble  out  1  insert NOP into MEM/WB
idex_bubble  out  1  insert NOP into ID/EX
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX
timeout_err  out  1  sticky memory timeout flag

Behaviour:
- Single clock domain, clk. rst is synchronous and active-high.
- While rst is high:
  - FSM goes to RUN and the wait counter goes to 0.
  - timeout_err is cleared.
  - All outputs are forced to 0.
  - This applies equally mid-MEM_WAIT and in ERR.
- FSM states: RUN, MEM_WAIT, ERR. State is registered. Control outputs are combinational from state and inputs, so they take effect in the cycle of detection (0-cycle latency).
- mem_wait_cond = mem_req & !mem_ready.
- Memory freeze is active when:
  - state is RUN and mem_wait_cond, or
  - state is MEM_WAIT and mem_wait_cond.
- When memory freeze is active:
  - pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble are all 1.
  - Flush and load-use outputs are 0.
- RUN -> MEM_WAIT on mem_wait_cond. Wait counter loads 1.
- MEM_WAIT transitions:
  - mem_ready=1: go to RUN. Freeze is deasserted that same cycle and the counter is cleared.
  - mem_req=0 (aborted access): go to RUN. No freeze that cycle.
  - Otherwise: counter increments. When the counter equals MEM_WAIT_MAX and mem_wait_cond still holds, go to ERR.
- ERR:
  - All five freeze outputs are held at 1 and timeout_err=1.
  - Only rst exits ERR.
- Taken-branch squash: in RUN with no freeze and br_taken=1, ifid_flush=1 and idex_flush=1 for that cycle. No stall is raised. Load-use detection is suppressed, because the ID instruction is wrong-path.
- Load-use hazard:
  - Condition: in RUN with no freeze and br_taken=0, idex_memread=1, idex_regrd!=0, and either (id_rs_used & id_rs==idex_regrd) or (id_rt_used & id_rt==idex_regrd).
  - Response: pc_stall=1, ifid_stall=1 and idex_bubble=1 for exactly that cycle. It self-clears next cycle because the bubble removes the load from EX.
- Register 0 is never a hazard source.
- Priority: ERR > memory freeze > branch squash > load-use.
- A br_taken held during a freeze is acted on in the release cycle, since EX is frozen and br_taken stays valid.
- A branch and a load-use in the same cycle produce the branch squash only.

Optional Feature:
Macro HAZARD_CTRL_PERF_EN.
- When defined, add three outputs:
  - perf_stall_cycles: counts cycles with any freeze or load-use stall active.
  - perf_flushes: counts branch-squash cycles.
  - perf_loaduse: counts load-use events.
- Each output is PERF_W bits, saturating at all-ones, cleared by rst, and does not count while rst is high.
- When undefined, the ports and logic are absent and the core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERR);
  - the REG_W default;
  - the PERF_W default;
  - the ZERO_REG constant.
- One sub-module, hazard_sat_cnt: a parameterised-width saturating counter with synchronous active-high reset and enable. It is instantiated three times under HAZARD_CTRL_PERF_EN.

Test Plan:
- Load-use: idex_memread=1, idex_regrd=5, id_rs=5, id_rs_used=1 -> pc_stall, ifid_stall and idex_bubble high for 1 cycle. Repeat with idex_regrd=0 or id_rs_used=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> all freeze outputs high for 3 cycles, low in the ready cycle, FSM back in RUN.
- Timeout: mem_req=1, mem_ready=0 held for 20 cycles -> ERR reached after MEM_WAIT_MAX (15) MEM_WAIT cycles; timeout_err sticky. Pulse rst -> all outputs 0, RUN.
- Branch plus load-use same cycle: br_taken=1 with load-use hazard present -> ifid_flush=idex_flush=1, pc_stall=0, idex_bubble=0.
- Branch during freeze: br_taken=1 throughout a 2-cycle wait -> no flush while frozen; flush asserted in the mem_ready cycle.
- With HAZARD_CTRL_PERF_EN defined and PERF_W=4: 20 load-use events -> perf_loaduse saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned HAZ_REG_W  = 4;
  localparam int unsigned HAZ_PERF_W = 16;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous active-high reset and count enable.
module hazard_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use detection, memory-wait freeze with timeout, branch squash.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W        = HAZ_REG_W,
  parameter int unsigned MEM_WAIT_MAX = 15
`ifdef HAZARD_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W       = HAZ_PERF_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_regrd,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             timeout_err
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flushes,
  output logic [PERF_W-1:0] perf_loaduse
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

  hazard_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic wait_cond;
  logic lu_hit;
  logic freeze;
  logic squash;
  logic load_use;

  assign wait_cond = mem_req & ~mem_ready;
  assign lu_hit    = idex_memread && (idex_regrd != REG_W'(ZERO_REG)) &&
                     ((id_rs_used && (id_rs == idex_regrd)) ||
                      (id_rt_used && (id_rt == idex_regrd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (wait_cond) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!wait_cond) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(MEM_WAIT_MAX)) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // The release cycle of a wait (MEM_WAIT without wait_cond) behaves like RUN,
  // so a branch held through the freeze is squashed exactly then.
  always_comb begin
    freeze   = 1'b0;
    squash   = 1'b0;
    load_use = 1'b0;
    if (!rst) begin
      if (state == ERR || wait_cond) begin
        freeze = 1'b1;
      end else if (br_taken) begin
        squash = 1'b1;
      end else begin
        load_use = lu_hit;
      end
    end
  end

  always_comb begin
    pc_stall     = freeze | load_use;
    ifid_stall   = freeze | load_use;
    idex_stall   = freeze;
    exmem_stall  = freeze;
    memwb_bubble = freeze;
    idex_bubble  = load_use;
    ifid_flush   = squash;
    idex_flush   = squash;
    timeout_err  = !rst && (state == ERR);
  end

`ifdef HAZARD_CTRL_PERF_EN
  hazard_sat_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze | load_use),
    .count (perf_stall_cycles)
  );

  hazard_sat_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (squash),
    .count (perf_flushes)
  );

  hazard_sat_cnt #(.W(PERF_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (load_use),
    .count (perf_loaduse)
  );
`endif

endmodule
